// File: rtl/cpu_mul_pkg.sv
// Shared op encodings and signedness-correction helpers for the pipelined multiplier.
// Correction terms turn the unsigned full product into the signed/mixed variant.
package cpu_mul_pkg;

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULXSS = 2'd1;
  localparam logic [1:0] OP_MULXSU = 2'd2;
  localparam logic [1:0] OP_MULXUU = 2'd3;

  function automatic logic op_is_high(input logic [1:0] op);
    return (op != OP_MUL);
  endfunction

  // A is signed for MULXSS and MULXSU; a negative A needs B subtracted from the high word.
  function automatic logic corr_a(input logic [1:0] op, input logic msb);
    return msb & ((op == OP_MULXSS) | (op == OP_MULXSU));
  endfunction

  function automatic logic corr_b(input logic [1:0] op, input logic msb);
    return msb & (op == OP_MULXSS);
  endfunction

endpackage

// File: rtl/cpu_mul_pp_array.sv
// Combinational generation of the four unsigned HALF_W x HALF_W partial products.
// Each operand is zero-extended so the multiply is explicitly full width.
module cpu_mul_pp_array
  import cpu_mul_pkg::*;
#(
  parameter int HALF_W = 16
) (
  input  logic [2*HALF_W-1:0] a,
  input  logic [2*HALF_W-1:0] b,
  output logic [2*HALF_W-1:0] p_ll,
  output logic [2*HALF_W-1:0] p_lh,
  output logic [2*HALF_W-1:0] p_hl,
  output logic [2*HALF_W-1:0] p_hh
);

  logic [2*HALF_W-1:0] a_lo, a_hi, b_lo, b_hi;

  assign a_lo = {{HALF_W{1'b0}}, a[HALF_W-1:0]};
  assign a_hi = {{HALF_W{1'b0}}, a[2*HALF_W-1:HALF_W]};
  assign b_lo = {{HALF_W{1'b0}}, b[HALF_W-1:0]};
  assign b_hi = {{HALF_W{1'b0}}, b[2*HALF_W-1:HALF_W]};

  assign p_ll = a_lo * b_lo;
  assign p_lh = a_lo * b_hi;
  assign p_hl = a_hi * b_lo;
  assign p_hh = a_hi * b_hi;

endmodule

// File: rtl/cpu_mul_pipe.sv
// Two-stage pipelined integer multiplier: stage 1 registers partial products,
// stage 2 sums them, applies signedness correction and selects the result word.
module cpu_mul_pipe
  import cpu_mul_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result
);

  localparam int HALF_W = DATA_W / 2;

  logic [DATA_W-1:0]   pp_ll, pp_lh, pp_hl, pp_hh;
  logic [DATA_W-1:0]   s1_p_ll, s1_p_lh, s1_p_hl, s1_p_hh;
  logic [DATA_W-1:0]   s1_a, s1_b;
  logic [1:0]          s1_op;
  logic                s1_corr_a, s1_corr_b, s1_valid;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   result_next;

  cpu_mul_pp_array #(.HALF_W(HALF_W)) u_pp (
    .a    (in_src1),
    .b    (in_src2),
    .p_ll (pp_ll),
    .p_lh (pp_lh),
    .p_hl (pp_hl),
    .p_hh (pp_hh)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_p_ll   <= '0;
      s1_p_lh   <= '0;
      s1_p_hl   <= '0;
      s1_p_hh   <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_op     <= '0;
      s1_corr_a <= 1'b0;
      s1_corr_b <= 1'b0;
    end else if (en) begin
      s1_p_ll   <= pp_ll;
      s1_p_lh   <= pp_lh;
      s1_p_hl   <= pp_hl;
      s1_p_hh   <= pp_hh;
      s1_a      <= in_src1;
      s1_b      <= in_src2;
      s1_op     <= in_op;
      s1_corr_a <= corr_a(in_op, in_src1[DATA_W-1]);
      s1_corr_b <= corr_b(in_op, in_src2[DATA_W-1]);
    end
  end

  always_comb begin
    prod = {{DATA_W{1'b0}}, s1_p_ll}
         + {{HALF_W{1'b0}}, s1_p_lh, {HALF_W{1'b0}}}
         + {{HALF_W{1'b0}}, s1_p_hl, {HALF_W{1'b0}}}
         + {s1_p_hh, {DATA_W{1'b0}}};
    if (s1_corr_a) prod = prod - {s1_b, {DATA_W{1'b0}}};
    if (s1_corr_b) prod = prod - {s1_a, {DATA_W{1'b0}}};
    result_next = op_is_high(s1_op) ? prod[2*DATA_W-1:DATA_W] : prod[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_result <= '0;
    end else if (en) begin
      out_result <= result_next;
    end
  end

  // Flush clears the valid bits even while stalled; data stays under en.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
    end
  end

endmodule

// File: tb/tb_cpu_mul_pipe.sv
// Directed bench for cpu_mul_pipe at DATA_W=32 and DATA_W=16 with hand-computed results.
module tb_cpu_mul_pipe;
  import cpu_mul_pkg::*;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, exp;
    logic [15:0] a16, b16, exp16;
  } vec_t;

  localparam int NV = 13;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_op = OP_MUL;
  logic [31:0] src1 = '0, src2 = '0;
  logic [15:0] src1_16 = '0, src2_16 = '0;
  logic        out_valid, out_valid16;
  logic [31:0] out_result;
  logic [15:0] out_result16;

  int n_vec = 0;
  int n_bad = 0;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  cpu_mul_pipe #(.DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .flush(flush), .in_valid(in_valid),
    .in_op(in_op), .in_src1(src1), .in_src2(src2),
    .out_valid(out_valid), .out_result(out_result)
  );

  cpu_mul_pipe #(.DATA_W(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .en(en), .flush(flush), .in_valid(in_valid),
    .in_op(in_op), .in_src1(src1_16), .in_src2(src2_16),
    .out_valid(out_valid16), .out_result(out_result16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [15:0] a16, input logic [15:0] b16);
    in_valid = v;
    in_op    = op;
    src1     = a;
    src2     = b;
    src1_16  = a16;
    src2_16  = b16;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{OP_MUL,    32'd7,        32'd6,        32'h0000002A, 16'd7,    16'd6,    16'h002A};
    vecs[1]  = '{OP_MULXUU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFE};
    vecs[2]  = '{OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 16'hFFFF, 16'hFFFF, 16'h0001};
    vecs[3]  = '{OP_MULXSS, 32'h80000000, 32'h80000000, 32'h40000000, 16'h8000, 16'h8000, 16'h4000};
    vecs[4]  = '{OP_MULXSS, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 16'hFFFF, 16'h0002, 16'hFFFF};
    vecs[5]  = '{OP_MULXSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    vecs[6]  = '{OP_MUL,    32'h00010000, 32'h00010000, 32'h00000000, 16'h0100, 16'h0100, 16'h0000};
    vecs[7]  = '{OP_MULXUU, 32'h00010000, 32'h00010000, 32'h00000001, 16'h0100, 16'h0100, 16'h0001};
    vecs[8]  = '{OP_MULXSS, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 16'hFFFF, 16'hFFFF, 16'h0000};
    vecs[9]  = '{OP_MULXSU, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 16'h8000, 16'h0002, 16'hFFFF};
    vecs[10] = '{OP_MULXSU, 32'h00000002, 32'h80000000, 32'h00000001, 16'h0002, 16'h8000, 16'h0001};
    vecs[11] = '{OP_MULXSS, 32'h00000002, 32'h80000000, 32'hFFFFFFFF, 16'h0002, 16'h8000, 16'hFFFF};
    vecs[12] = '{OP_MUL,    32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 16'hFFFF, 16'h0002, 16'hFFFE};

    #12;
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", out_result, 32'd0);
    chk("reset_valid16", {31'd0, out_valid16}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Single op: exactly two enabled edges of latency.
    drive(1'b1, OP_MUL, 32'd7, 32'd6, 16'd7, 16'd6);
    step();
    drive(1'b0, OP_MUL, 32'd0, 32'd0, 16'd0, 16'd0);
    chk("lat_edge1_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("lat_edge2_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_edge2_result", out_result, 32'h2A);
    step();
    chk("lat_edge3_valid", {31'd0, out_valid}, 32'd0);

    // Back-to-back table: result of vector i-1 visible after edge i.
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].a16, vecs[i].b16);
      else        drive(1'b0, OP_MUL, 32'd0, 32'd0, 16'd0, 16'd0);
      step();
      if (i >= 1) begin
        chk($sformatf("vec%0d_valid", i-1), {31'd0, out_valid}, 32'd1);
        chk($sformatf("vec%0d_result", i-1), out_result, vecs[i-1].exp);
        chk($sformatf("vec%0d_valid16", i-1), {31'd0, out_valid16}, 32'd1);
        chk($sformatf("vec%0d_result16", i-1), {16'd0, out_result16}, {16'd0, vecs[i-1].exp16});
      end
    end
    drive(1'b0, OP_MUL, 32'd0, 32'd0, 16'd0, 16'd0);
    step();

    // Stall: 15 held across two stalled edges, then 16.
    drive(1'b1, OP_MUL, 32'd3, 32'd5, 16'd3, 16'd5);
    step();
    drive(1'b1, OP_MUL, 32'd4, 32'd4, 16'd4, 16'd4);
    step();
    chk("stall_first", out_result, 32'd15);
    drive(1'b0, OP_MUL, 32'd9, 32'd9, 16'd9, 16'd9);
    en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("stall_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_hold_result", out_result, 32'd15);
    end
    en = 1'b1;
    step();
    chk("stall_second_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_second_result", out_result, 32'd16);
    step();
    chk("stall_no_dup", {31'd0, out_valid}, 32'd0);

    // Flush one cycle after issue kills the op.
    drive(1'b1, OP_MUL, 32'd2, 32'd2, 16'd2, 16'd2);
    step();
    drive(1'b0, OP_MUL, 32'd0, 32'd0, 16'd0, 16'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_s1_edge1", {31'd0, out_valid}, 32'd0);
    step();
    chk("flush_s1_edge2", {31'd0, out_valid}, 32'd0);

    // in_valid together with flush: dropped.
    drive(1'b1, OP_MUL, 32'd2, 32'd3, 16'd2, 16'd3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, OP_MUL, 32'd0, 32'd0, 16'd0, 16'd0);
    step();
    chk("flush_same_cycle", {31'd0, out_valid}, 32'd0);
    chk("flush_same_cycle16", {31'd0, out_valid16}, 32'd0);

    // Flush while stalled still clears out_valid.
    drive(1'b1, OP_MUL, 32'd5, 32'd5, 16'd5, 16'd5);
    step();
    drive(1'b0, OP_MUL, 32'd0, 32'd0, 16'd0, 16'd0);
    step();
    chk("pre_flush_valid", {31'd0, out_valid}, 32'd1);
    en = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_stall_valid", {31'd0, out_valid}, 32'd0);
    en = 1'b1;
    step();
    chk("flush_stall_after", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset between edges with two ops in flight.
    drive(1'b1, OP_MUL, 32'd6, 32'd7, 16'd6, 16'd7);
    step();
    drive(1'b1, OP_MUL, 32'd8, 32'd8, 16'd8, 16'd8);
    step();
    drive(1'b0, OP_MUL, 32'd0, 32'd0, 16'd0, 16'd0);
    chk("inflight_valid", {31'd0, out_valid}, 32'd1);
    chk("inflight_result", out_result, 32'd42);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_result", out_result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("post_rst_valid16", {31'd0, out_valid16}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_mul_pipe.md
Name: cpu_mul_pipe

Overview:
- Parametrised, pipelined integer multiplier for the Nios II custom-datapath family, successor to the fixed 3-partial-product mult cell.
- Computes the full 2*DATA_W-bit product with selectable operand signedness, and returns either the low word (MUL) or the high word (MULXSS/MULXSU/MULXUU).
- Adds valid tracking, stall and flush.
- Sits between E-stage operand muxes and M/W-stage writeback.

Parameters:
- DATA_W, 32, operand/result width; must be even and >= 4.
- HALF_W, DATA_W/2, partial-product operand width; derived, not overridable.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- en  in  1  pipeline advance; 0 = stall, all registers hold
- flush  in  1  kill all in-flight operations
- in_valid  in  1  operation presented this cycle
- in_op  in  2  0=MUL, 1=MULXSS, 2=MULXSU, 3=MULXUU
- in_src1  in  DATA_W  operand A
- in_src2  in  DATA_W  operand B
- out_valid  out  1  out_result holds a completed operation
- out_result  out  DATA_W  selected product word

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low on reset_n. Reset clears every register to 0, so out_valid=0 and out_result=0. Assertion mid-operation discards all in-flight work.
- Stage 1 (when en=1) registers:
  - four unsigned HALF_W x HALF_W partial products: p_ll=Alo*Blo, p_lh=Alo*Bhi, p_hl=Ahi*Blo, p_hh=Ahi*Bhi;
  - the op;
  - corrA = (op in {MULXSS, MULXSU}) & A[msb];
  - corrB = (op == MULXSS) & B[msb];
  - A and B;
  - s1_valid = in_valid & ~flush.
- Stage 2 (when en=1):
  - prod = p_ll + (p_lh<<HALF_W) + (p_hl<<HALF_W) + (p_hh<<DATA_W), modulo 2^(2*DATA_W);
  - subtract (B<<DATA_W) if corrA, and (A<<DATA_W) if corrB;
  - out_result = prod[DATA_W-1:0] for MUL, else prod[2*DATA_W-1:DATA_W];
  - out_valid = s1_valid & ~flush.
- Signedness: MUL's low word is signedness-independent and uses no correction. MULXSU treats A as signed and B as unsigned.
- Latency: exactly 2 enabled clock edges from in_valid sampled to out_valid. Throughput is one op per enabled cycle.
- Stall: when en=0, all data and valid registers hold, and out_valid/out_result remain stable.
- Flush:
  - Takes precedence over en. At the next edge it clears s1_valid and out_valid, even when en=0.
  - Data registers follow en as normal; their contents are don't-care once invalid.
  - in_valid together with flush: the input is dropped.
- out_valid behaves as a level, not a pulse. It stays high across stalls until the next enabled edge loads a new (possibly invalid) stage-2 result.
- No internal state beyond the two stages. No backpressure output; the consumer controls en.

Decomposition:
- Package cpu_mul_pkg holds:
  - op encodings OP_MUL, OP_MULXSS, OP_MULXSU, OP_MULXUU (2-bit localparams);
  - function op_is_high(op);
  - function corr_a/corr_b(op, msb).
- One sub-module, cpu_mul_pp_array:
  - combinational HALF_W-parameterised generation of the four unsigned partial products;
  - instantiated once by cpu_mul_pipe, which owns all registers.

Test Plan:
- MUL 7 x 6, in_valid one cycle, en=1 -> out_valid high 2 cycles later, out_result=0x0000002A.
- MULXUU 0xFFFFFFFF x 0xFFFFFFFF -> out_result=0xFFFFFFFE. MUL with the same operands -> 0x00000001.
- MULXSS 0x80000000 x 0x80000000 -> 0x40000000. MULXSS 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF. MULXSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Stall: issue MUL 3x5 at c0 and MUL 4x4 at c1, en=0 for c2-c3, en=1 from c4 -> 15 visible and held through the stall, then 16 one enabled edge later. No op is lost or duplicated.
- Flush timing: op at c0, flush at c1 -> out_valid never asserts. in_valid+flush in the same cycle -> no output. Flush with en=0 still clears out_valid.
- Reset mid-flight: two ops issued, reset_n low asynchronously between edges -> out_valid and out_result go 0 immediately, with no completion after release. DATA_W=16 regression of scenarios 1-3 with scaled values: MULXUU 0xFFFF x 0xFFFF -> 0xFFFE.
